// File: rtl/counter_bank.sv
// Bank of N_CH up/down counters sharing one programmable prescaler tick.
// Define COUNTER_BANK_CAPTURE_EN to add the capture/snap atomic snapshot port.
module counter_bank #(
  parameter int N_CH  = 2,
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic [DIV_W-1:0]      div_reload,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       ch_clear,
  input  logic [N_CH-1:0]       ch_up,
  input  logic [N_CH-1:0]       ch_down,
  input  logic [N_CH-1:0]       ch_sat,
  input  logic [N_CH*WIDTH-1:0] ch_limit,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       eq_zero,
  output logic [N_CH-1:0]       eq_limit,
  output logic [N_CH-1:0]       wrap,
`ifdef COUNTER_BANK_CAPTURE_EN
  input  logic                  capture,
  output logic [N_CH*WIDTH-1:0] snap,
`endif
  output logic                  tick
);

  logic [DIV_W-1:0] div_cnt;
  logic [WIDTH-1:0] cnt_q    [N_CH];
  logic [WIDTH-1:0] cnt_nxt  [N_CH];
  logic [N_CH-1:0]  wrap_nxt;

  // Prescaler: tick is registered, so it is high the cycle after the reload.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= div_reload;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt - 1'b1;
      tick    <= 1'b0;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] lim;
    cur      = '0;
    lim      = '0;
    wrap_nxt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cur        = cnt_q[i];
      lim        = ch_limit[i*WIDTH +: WIDTH];
      cnt_nxt[i] = cur;
      if (ch_clear[i]) begin
        cnt_nxt[i] = '0;
      end else if (ch_up[i] || (!ch_down[i] && ch_en[i] && tick)) begin
        // Autocount only fires when no explicit step is pending.
        if (cur < lim) begin
          cnt_nxt[i] = cur + 1'b1;
        end else if (ch_sat[i]) begin
          cnt_nxt[i] = lim;
        end else begin
          cnt_nxt[i]  = '0;
          wrap_nxt[i] = 1'b1;
        end
      end else if (ch_down[i]) begin
        if (cur == '0) begin
          if (!ch_sat[i]) begin
            cnt_nxt[i]  = lim;
            wrap_nxt[i] = 1'b1;
          end
        end else if (cur > lim) begin
          cnt_nxt[i] = lim;
        end else begin
          cnt_nxt[i] = cur - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      wrap     <= '0;
      eq_zero  <= '1;
      eq_limit <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]    <= cnt_nxt[i];
        eq_zero[i]  <= (cnt_q[i] == '0);
        eq_limit[i] <= (cnt_q[i] == ch_limit[i*WIDTH +: WIDTH]);
      end
      wrap <= wrap_nxt;
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N_CH; i++) count[i*WIDTH +: WIDTH] = cnt_q[i];
  end

`ifdef COUNTER_BANK_CAPTURE_EN
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)     snap <= '0;
    else if (capture) snap <= count;
  end
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: random stimulus against a cycle-level
// behavioural model of the counters and prescaler.
module tb_counter_bank;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int DW = 24;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] div_reload = '0;
  logic [N-1:0]  ch_en = '0, ch_clear = '0, ch_up = '0, ch_down = '0, ch_sat = '0;
  logic [N*W-1:0] ch_limit = '0;
  logic [N*W-1:0] count;
  logic [N-1:0]  eq_zero, eq_limit, wrap;
  logic          tick;
`ifdef COUNTER_BANK_CAPTURE_EN
  logic          capture = 1'b0;
  logic [N*W-1:0] snap;
  logic [N*W-1:0] m_snap;
`endif

  counter_bank #(.N_CH(N), .WIDTH(W), .DIV_W(DW)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .div_reload(div_reload),
    .ch_en(ch_en), .ch_clear(ch_clear), .ch_up(ch_up), .ch_down(ch_down),
    .ch_sat(ch_sat), .ch_limit(ch_limit), .count(count),
    .eq_zero(eq_zero), .eq_limit(eq_limit), .wrap(wrap),
`ifdef COUNTER_BANK_CAPTURE_EN
    .capture(capture), .snap(snap),
`endif
    .tick(tick)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Model state: counts as plain integers, tick derived from edges since reset release.
  int       m_cnt [N];
  bit [N-1:0] m_wrap, m_eqz, m_eql;
  bit       m_tick;
  int       m_edge;

  function automatic int lim_of(int i);
    return int'(ch_limit[i*W +: W]);
  endfunction

  function automatic logic [N*W-1:0] exp_count();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_cnt[i]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_wrap = '0; m_eqz = '1; m_eql = '0; m_tick = 0; m_edge = 0;
`ifdef COUNTER_BANK_CAPTURE_EN
    m_snap = '0;
`endif
  endfunction

  function automatic void model_step();
    int nc [N];
    bit [N-1:0] nw;
    nw = '0;
`ifdef COUNTER_BANK_CAPTURE_EN
    if (capture) m_snap = exp_count();
`endif
    for (int i = 0; i < N; i++) begin
      int c, lim;
      c = m_cnt[i];
      lim = lim_of(i);
      nc[i] = c;
      if (ch_clear[i]) nc[i] = 0;
      else if (ch_up[i] || (!ch_down[i] && ch_en[i] && m_tick)) begin
        if (c < lim) nc[i] = c + 1;
        else if (ch_sat[i]) nc[i] = lim;
        else begin nc[i] = 0; nw[i] = 1; end
      end else if (ch_down[i]) begin
        if (c == 0) begin
          if (!ch_sat[i]) begin nc[i] = lim; nw[i] = 1; end
        end else if (c > lim) nc[i] = lim;
        else nc[i] = c - 1;
      end
      m_eqz[i] = (c == 0);
      m_eql[i] = (c == lim);
    end
    for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
    m_wrap = nw;
    m_tick = ((m_edge % (int'(div_reload) + 1)) == 0);
    m_edge++;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge sys_clk);
    total++; if (count !== '0)     begin bad++; $display("FAIL reset_count: got %h want 0", count); end
    total++; if (eq_zero !== '1)   begin bad++; $display("FAIL reset_eq_zero: got %b want 11", eq_zero); end
    total++; if (eq_limit !== '0)  begin bad++; $display("FAIL reset_eq_limit: got %b want 00", eq_limit); end
    total++; if (wrap !== '0)      begin bad++; $display("FAIL reset_wrap: got %b want 00", wrap); end
    total++; if (tick !== 1'b0)    begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_prescale();
    int ticks;
    ticks = 0;
    div_reload = 3; ch_en = 2'b01; ch_limit = {8'd200, 8'd200}; ch_sat = '0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle();
      ticks += int'(tick);
      total++; if (tick !== m_tick)      begin bad++; $display("FAIL prescale_tick: got %b want %b", tick, m_tick); end
      total++; if (count !== exp_count()) begin bad++; $display("FAIL prescale_count: got %h want %h", count, exp_count()); end
      total++; if (eq_zero !== m_eqz)    begin bad++; $display("FAIL prescale_eq_zero: got %b want %b", eq_zero, m_eqz); end
    end
    total++; if (ticks != 5) begin bad++; $display("FAIL prescale_tick_count: got %0d want 5", ticks); end
  endtask

  task automatic test_wrap();
    int wraps;
    wraps = 0;
    div_reload = 0; ch_en = 2'b01; ch_limit = {8'd9, 8'd5}; ch_sat = '0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cycle();
      wraps += int'(wrap[0]);
      total++; if (count !== exp_count()) begin bad++; $display("FAIL wrap_count: got %h want %h", count, exp_count()); end
      total++; if (wrap !== m_wrap)      begin bad++; $display("FAIL wrap_pulse: got %b want %b", wrap, m_wrap); end
      total++; if (eq_limit !== m_eql)   begin bad++; $display("FAIL wrap_eq_limit: got %b want %b", eq_limit, m_eql); end
    end
    total++; if (wraps != 2) begin bad++; $display("FAIL wrap_pulse_count: got %0d want 2", wraps); end
    ch_en = '0;
  endtask

  task automatic test_sat();
    ch_en = '0; ch_sat = 2'b01; ch_limit = {8'd9, 8'd5};
    do_reset();
    ch_down = 2'b01;
    repeat (3) begin
      cycle();
      total++; if (count[W-1:0] !== 8'd0 || wrap[0] !== 1'b0) begin bad++; $display("FAIL sat_down: got %h/%b want 00/0", count[W-1:0], wrap[0]); end
    end
    ch_down = '0; ch_up = 2'b01;
    repeat (7) begin
      cycle();
      total++; if (count !== exp_count() || wrap !== m_wrap) begin bad++; $display("FAIL sat_up: got %h/%b want %h/%b", count, wrap, exp_count(), m_wrap); end
    end
    ch_up = '0;
    total++; if (count[W-1:0] !== 8'd5) begin bad++; $display("FAIL sat_hold_limit: got %h want 05", count[W-1:0]); end
    ch_sat = '0;
  endtask

  task automatic test_priority();
    ch_en = '0; ch_sat = '0; ch_limit = {8'd10, 8'd5};
    do_reset();
    ch_up = 2'b10; repeat (3) cycle();
    ch_down = 2'b10; cycle();
    total++; if (count[2*W-1:W] !== 8'd4) begin bad++; $display("FAIL prio_up_down: got %h want 04", count[2*W-1:W]); end
    ch_down = '0; ch_clear = 2'b10; cycle();
    total++; if (count[2*W-1:W] !== 8'd0 || wrap[1] !== 1'b0) begin bad++; $display("FAIL prio_clear_up: got %h/%b want 00/0", count[2*W-1:W], wrap[1]); end
    ch_clear = '0; repeat (3) cycle();
    ch_limit = {8'd2, 8'd5}; cycle();
    total++; if (count[2*W-1:W] !== 8'd0 || wrap[1] !== 1'b1) begin bad++; $display("FAIL prio_limit_lowered: got %h/%b want 00/1", count[2*W-1:W], wrap[1]); end
    ch_up = '0; ch_down = 2'b10; cycle(); cycle();
    total++; if (count !== exp_count() || wrap !== m_wrap) begin bad++; $display("FAIL prio_down: got %h/%b want %h/%b", count, wrap, exp_count(), m_wrap); end
    ch_down = '0;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    div_reload = 0; ch_en = 2'b01; ch_sat = '0; ch_limit = {8'd255, 8'd255};
    do_reset();
    while (m_cnt[0] != 127 && guard < 300) begin cycle(); guard++; end
    total++; if (count[W-1:0] !== 8'h7F) begin bad++; $display("FAIL areset_precount: got %h want 7f", count[W-1:0]); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (count !== '0 || eq_zero !== '1) begin bad++; $display("FAIL areset_immediate: got %h/%b want 0000/11", count, eq_zero); end
    total++; if (tick !== 1'b0 || wrap !== '0) begin bad++; $display("FAIL areset_pulses: got tick=%b wrap=%b want 0/00", tick, wrap); end
    @(negedge sys_clk);
    model_reset();
    reset_n = 1'b1;
    repeat (8) begin
      cycle();
      total++; if (count !== exp_count() || tick !== m_tick) begin bad++; $display("FAIL areset_resume: got %h/%b want %h/%b", count, tick, exp_count(), m_tick); end
    end
    ch_en = '0;
  endtask

  task automatic test_random();
    div_reload = DW'($urandom_range(0, 3));
    ch_sat = N'($urandom);
    ch_limit = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ch_en    = N'($urandom);
      ch_up    = N'($urandom) & N'($urandom);
      ch_down  = N'($urandom) & N'($urandom);
      ch_clear = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 31) == 0) ch_limit = {8'($urandom_range(0, 12)), 8'($urandom)};
      if ($urandom_range(0, 63) == 0) ch_sat = N'($urandom);
`ifdef COUNTER_BANK_CAPTURE_EN
      capture = ($urandom_range(0, 7) == 0);
`endif
      cycle();
      total++; if (count !== exp_count()) begin bad++; $display("FAIL rand_count: got %h want %h", count, exp_count()); end
      total++; if (wrap !== m_wrap)       begin bad++; $display("FAIL rand_wrap: got %b want %b", wrap, m_wrap); end
      total++; if (eq_zero !== m_eqz || eq_limit !== m_eql) begin bad++; $display("FAIL rand_flags: got z=%b l=%b want z=%b l=%b", eq_zero, eq_limit, m_eqz, m_eql); end
      total++; if (tick !== m_tick)       begin bad++; $display("FAIL rand_tick: got %b want %b", tick, m_tick); end
`ifdef COUNTER_BANK_CAPTURE_EN
      total++; if (snap !== m_snap)       begin bad++; $display("FAIL rand_snap: got %h want %h", snap, m_snap); end
`endif
    end
    ch_en = '0; ch_up = '0; ch_down = '0; ch_clear = '0;
`ifdef COUNTER_BANK_CAPTURE_EN
    capture = 1'b0;
`endif
  endtask

`ifdef COUNTER_BANK_CAPTURE_EN
  task automatic test_capture();
    logic [N*W-1:0] held;
    div_reload = 0; ch_en = 2'b11; ch_sat = '0; ch_limit = {8'd200, 8'd200};
    do_reset();
    repeat (5) cycle();
    held = count;
    capture = 1'b1; cycle(); capture = 1'b0;
    repeat (5) begin
      cycle();
      total++; if (snap !== held) begin bad++; $display("FAIL capture_hold: got %h want %h", snap, held); end
    end
    ch_en = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_prescale();
    test_wrap();
    test_sat();
    test_priority();
    test_async_reset();
    test_random();
`ifdef COUNTER_BANK_CAPTURE_EN
    test_capture();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
